io_controller: RTL and testbench
================================

# io_controller

Board-side I/O responder for the single-cycle processor. It services the `in`, `out` and `halt` strobes produced by the control unit's opcode decode. For IN, it stalls the core until the user confirms a switch value with a debounced pushbutton, then returns that value for write-back. For OUT, it latches a register value into the display register, and on HALT it freezes the core until reset. It sits between the datapath and the board switches, button and 7-segment driver.

## Interface
Parameters:
- `DATA_W`, 32, datapath width.
- `SW_W`, 16, number of board switches; must satisfy `SW_W ≤ DATA_W`.
- `DEBOUNCE_CYCLES`, 50000, stable cycles required before the debounced button level changes; must be ≥ 2.

Ports:
- `clock`, input, 1, single system clock; all state is updated on its rising edge.
- `reset`, input, 1, asynchronous, active-low reset.
- `in_req`, input, 1, IN instruction present (decode `in`).
- `out_req`, input, 1, OUT instruction present (decode `out`).
- `halt`, input, 1, HALT instruction present.
- `out_data`, input, DATA_W, register value to display.
- `sw`, input, SW_W, raw board switches; treated as asynchronous.
- `btn_n`, input, 1, raw confirm pushbutton, active-low; asynchronous and bouncy.
- `stall`, output, 1, freeze the PC and register/memory writes.
- `in_data`, output, DATA_W, captured switch value, zero-extended to DATA_W.
- `in_valid`, output, 1, one-cycle write-enable for the IN destination register.
- `disp_value`, output, DATA_W, display register.
- `disp_valid`, output, 1, sticky; set by the first OUT.
- `halted`, output, 1, core is halted.

## Operation
- Button path:
  - `btn_n` is inverted and passed through a 2-FF synchronizer.
  - The debounced level `btn_db` changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - The debounce counter clears on any cycle where the synchronized level equals `btn_db`.
  - `press` is a one-cycle pulse on the 0→1 transition of `btn_db`; `release` is a one-cycle pulse on its 1→0 transition.
- `sw` passes through a 2-FF synchronizer; the capture point uses the synchronized value.
- FSM states and transitions:
  - IDLE:
    - Priority order is `halt` > `in_req` > `out_req`.
    - `halt` → HALTED.
    - `in_req` → WAIT_PRESS.
    - `out_req`: `disp_value` ← `out_data` and `disp_valid` ← 1 on the same edge; the state stays IDLE.
  - WAIT_PRESS: on `press`, `in_data` ← zero-extended synchronized `sw`, then → WAIT_RELEASE. All other events are ignored.
  - WAIT_RELEASE: on `release` → DONE.
  - DONE: → IDLE unconditionally.
  - HALTED: absorbing; only reset leaves this state.
- A button already held when the FSM enters WAIT_PRESS does not capture. The user must release and press again.
- `in_data` holds its value until the next capture; later `sw` changes have no effect on it.
- `in_req` and `out_req` asserted together is illegal; IN wins and the OUT is dropped.
- `in_req` falling in WAIT_PRESS or WAIT_RELEASE is ignored; the FSM completes the transaction.

## Timing
- `stall` is combinational (Mealy):
  - 1 when the state is IDLE and (`in_req` or `halt`) is 1.
  - 1 in WAIT_PRESS, WAIT_RELEASE and HALTED.
  - 0 in DONE.
- The core therefore never advances past an IN or HALT in the cycle the instruction appears.
- `in_valid` = 1 only in DONE, for exactly one cycle, with `stall` = 0. The core writes back and advances on that edge.
- OUT has zero stall cycles. `disp_value` updates on the edge that ends the OUT cycle.
- `halted` = 1 in HALTED, registered; it rises on the edge after `halt` is seen in IDLE.
- Button latency: a raw level change takes 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles to change `btn_db`. The pulse appears in the following cycle.
- Minimum IN duration is DONE plus 1 cycle after the debounced release.
- Reset, including mid-transaction:
  - State → IDLE.
  - `stall`, `in_valid`, `halted` and `disp_valid` → 0.
  - `in_data` and `disp_value` → 0.
  - Synchronizers and `btn_db` → 0, i.e. button released.
  - Debounce counter → 0.
- The debounce counter width is $clog2(`DEBOUNCE_CYCLES`+1) and it saturates; it must not wrap.

## Structure
- Shared package `io_defs`: FSM state encodings (IDLE=0, WAIT_PRESS=1, WAIT_RELEASE=2, DONE=3, HALTED=4; 3-bit) and the default `DEBOUNCE_CYCLES`.
- Sub-module `btn_debounce`:
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clock`, `reset`, `btn_n`, `level`, `press`, `release`.
  - Contains the inversion, synchronizer, counter and edge pulses.
- The top level contains the `sw` synchronizer, FSM, capture register and display register.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
- Reset: assert `reset`=0 mid-sim → all outputs 0 immediately. Deassert, idle 10 cycles → `stall`=0 throughout.
- OUT: `out_data`=0x000000A5 with `out_req` for 1 cycle → next edge `disp_value`=0xA5, `disp_valid`=1, `stall` never 1. A second OUT of 0x7 → `disp_value`=0x7.
- IN: `sw`=0x1234, `in_req` held, press 10 cycles then release → `stall`=1 from the first `in_req` cycle until DONE. Single `in_valid` pulse with `in_data`=0x00001234. `sw`→0x5555 after capture leaves `in_data` unchanged.
- Bounce and held button:
  - 2-cycle glitches on `btn_n` in WAIT_PRESS → no capture, `stall` stays 1.
  - Button held before `in_req` → no capture until release followed by a new press.
- HALT and reset: `halt` in IDLE → `stall`=1 that cycle, `halted`=1 next edge, later `in_req`/`out_req` ignored. Separately, reset during WAIT_RELEASE → IDLE, `stall`=0, and no `in_valid` is produced.

Source files
------------

// File: rtl/io_defs_pkg.sv
// Shared definitions for the board I/O responder: FSM encodings and the
// default button debounce length.
package io_defs;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_PRESS   = 3'd1,
    ST_WAIT_RELEASE = 3'd2,
    ST_DONE         = 3'd3,
    ST_HALTED       = 3'd4
  } io_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: invert the active-low raw input, synchronize it,
// debounce it and emit one-cycle press/release pulses.
module btn_debounce
  import io_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_comb begin
    sync_d = {sync_q[0], ~btn_n};
    db_d   = db_q;
    cnt_d  = cnt_q;
    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = db_d & ~db_q;
    rel_d   = ~db_d & db_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level         = db_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/io_controller.sv
// Board-side I/O responder: stalls the core for IN until a debounced button
// confirms the switches, latches OUT values for display, and freezes on HALT.
module io_controller
  import io_defs::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  input  logic              out_req,
  input  logic              halt,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn_n,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_valid,
  output logic              halted,
  output logic [2:0]        state_dbg
);

  // Handshake: in_req/halt are held by the core while stall is high; the core
  // advances on any edge where stall is low, writing in_data when in_valid is high.

  io_state_e         state_q, state_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [DATA_W-1:0] disp_value_q, disp_value_d;
  logic              disp_valid_q, disp_valid_d;
  logic              halted_q;
  logic              btn_level;
  logic              btn_press;
  logic              btn_release;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock        (clock),
    .reset        (reset),
    .btn_n        (btn_n),
    .level        (btn_level),
    .press        (btn_press),
    .release_pulse(btn_release)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      in_data_q    <= '0;
      disp_value_q <= '0;
      disp_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sw_s1_q      <= sw;
      sw_s2_q      <= sw_s1_q;
      in_data_q    <= in_data_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      halted_q     <= (state_d == ST_HALTED);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (halt)        state_d = ST_HALTED;
        else if (in_req) state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS:   if (btn_press)   state_d = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: if (btn_release) state_d = ST_DONE;
      ST_DONE:         state_d = ST_IDLE;
      ST_HALTED:       state_d = ST_HALTED;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_data_d    = in_data_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    if (state_q == ST_WAIT_PRESS && btn_press) begin
      in_data_d = DATA_W'(sw_s2_q);
    end
    // halt and in_req both outrank a simultaneous out_req.
    if (state_q == ST_IDLE && out_req && !halt && !in_req) begin
      disp_value_d = out_data;
      disp_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall    = 1'b0;
    in_valid = 1'b0;
    unique case (state_q)
      ST_IDLE:         stall = in_req | halt;
      ST_WAIT_PRESS,
      ST_WAIT_RELEASE,
      ST_HALTED:       stall = 1'b1;
      ST_DONE:         in_valid = 1'b1;
      default:         stall = 1'b0;
    endcase
  end

  assign in_data    = in_data_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;
  assign halted     = halted_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_io_controller.sv
// Directed-vector bench for io_controller with a short debounce window.
module tb_io_controller;

  localparam int DW = 32;
  localparam int SWW = 16;

  logic          clock;
  logic          reset;
  logic          in_req, out_req, halt, btn_n;
  logic [DW-1:0] out_data;
  logic [SWW-1:0] sw;
  logic          stall, in_valid, disp_valid, halted;
  logic [DW-1:0] in_data, disp_value;
  logic [2:0]    state_dbg;

  int total;
  int bad;
  logic [DW-1:0] exp_disp;

  io_controller #(.DATA_W(DW), .SW_W(SWW), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in_req(in_req), .out_req(out_req),
    .halt(halt), .out_data(out_data), .sw(sw), .btn_n(btn_n),
    .stall(stall), .in_data(in_data), .in_valid(in_valid),
    .disp_value(disp_value), .disp_valid(disp_valid), .halted(halted),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, DW'(stall), 0);
    check_eq({tag, "_in_valid"}, DW'(in_valid), 0);
    check_eq({tag, "_halted"}, DW'(halted), 0);
    check_eq({tag, "_disp_valid"}, DW'(disp_valid), 0);
    check_eq({tag, "_in_data"}, in_data, 0);
    check_eq({tag, "_disp_value"}, disp_value, 0);
    check_eq({tag, "_state"}, DW'(state_dbg), 0);
  endtask

  task automatic do_out(input logic [DW-1:0] val);
    @(negedge clock);
    out_data = val;
    out_req  = 1'b1;
    #1 check_eq("out_stall", DW'(stall), 0);
    tick();
    out_req = 1'b0;
    check_eq("out_disp_value", disp_value, val);
    check_eq("out_disp_valid", DW'(disp_valid), 1);
    check_eq("out_stall_after", DW'(stall), 0);
  endtask

  // Press for 10 cycles, release, expect a single in_valid carrying exp_data.
  task automatic finish_in(input logic [DW-1:0] exp_data);
    bit seen;
    btn_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("press_stall", DW'(stall), 1);
      check_eq("press_no_valid", DW'(in_valid), 0);
    end
    btn_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (in_valid) seen = 1'b1;
      else check_eq("release_stall", DW'(stall), 1);
    end
    check_eq("in_valid_seen", DW'(seen), 1);
    check_eq("done_stall", DW'(stall), 0);
    check_eq("done_in_data", in_data, exp_data);
    in_req = 1'b0;
    tick();
    check_eq("valid_one_cycle", DW'(in_valid), 0);
    check_eq("back_idle", DW'(state_dbg), 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    in_req = 1'b0; out_req = 1'b0; halt = 1'b0; btn_n = 1'b1;
    out_data = '0; sw = '0;
    #1 check_all_zero("por");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_stall", DW'(stall), 0);
    end

    // OUT
    do_out(32'h0000_00A5);
    do_out(32'h0000_0007);
    exp_disp = 32'h7;

    // IN with a simultaneous (dropped) OUT on its first cycle
    sw = 16'h1234;
    @(negedge clock);
    in_req = 1'b1; out_req = 1'b1; out_data = 32'h0000_0BAD;
    #1 check_eq("in_first_stall", DW'(stall), 1);
    @(negedge clock);
    out_req = 1'b0;
    finish_in(32'h0000_1234);
    check_eq("in_out_dropped", disp_value, exp_disp);
    sw = 16'h5555;
    repeat (5) tick();
    check_eq("in_data_hold", in_data, 32'h0000_1234);

    // Bounce glitches in WAIT_PRESS
    sw = 16'h00C3;
    @(negedge clock);
    in_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      btn_n = 1'b0;
      repeat (2) tick();
      btn_n = 1'b1;
      repeat (3) begin
        tick();
        check_eq("glitch_stall", DW'(stall), 1);
        check_eq("glitch_no_valid", DW'(in_valid), 0);
      end
    end
    check_eq("glitch_state", DW'(state_dbg), 1);
    check_eq("glitch_in_data", in_data, 32'h0000_1234);
    finish_in(32'h0000_00C3);

    // Button held before in_req
    sw = 16'h00AA;
    btn_n = 1'b0;
    repeat (10) tick();
    in_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("held_stall", DW'(stall), 1);
      check_eq("held_no_valid", DW'(in_valid), 0);
    end
    check_eq("held_state", DW'(state_dbg), 1);
    btn_n = 1'b1;
    repeat (10) tick();
    check_eq("held_released_state", DW'(state_dbg), 1);
    check_eq("held_in_data", in_data, 32'h0000_00C3);
    finish_in(32'h0000_00AA);

    // Reset during WAIT_RELEASE
    @(negedge clock);
    in_req = 1'b1;
    btn_n = 1'b0;
    repeat (10) tick();
    check_eq("wr_state", DW'(state_dbg), 2);
    in_req = 1'b0;
    btn_n = 1'b1;
    reset = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq("post_reset_no_valid", DW'(in_valid), 0);
      check_eq("post_reset_stall", DW'(stall), 0);
    end

    // HALT
    do_out(32'h0000_0033);
    exp_disp = 32'h33;
    @(negedge clock);
    halt = 1'b1;
    #1 check_eq("halt_stall", DW'(stall), 1);
    check_eq("halt_not_yet", DW'(halted), 0);
    tick();
    halt = 1'b0;
    check_eq("halted_set", DW'(halted), 1);
    in_req = 1'b1; out_req = 1'b1; out_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("halted_stall", DW'(stall), 1);
      check_eq("halted_hold", DW'(halted), 1);
    end
    check_eq("halted_disp", disp_value, exp_disp);
    check_eq("halted_state", DW'(state_dbg), 4);
    in_req = 1'b0; out_req = 1'b0;
    reset = 1'b0;
    #1 check_all_zero("halt_reset");
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_eq("after_halt_reset_stall", DW'(stall), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
